// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter.
// Buffers scan-code bytes in a small FIFO and sends each one as an 11-bit
// PS/2 frame (start 0, data LSB first, odd parity, stop 1). The block
// generates both ps2_clk and ps2_data.
//
// Ports:
//   clk       system clock, rising edge
//   clrn      asynchronous active-low reset
//   wr_en     push wr_data into the FIFO this cycle
//   wr_data   scan-code byte to send
//   full      FIFO holds 2^ADDR_W entries
//   empty     FIFO holds 0 entries
//   overflow  sticky, set by a write while full
//   busy      frame or inter-frame gap in progress
//   done      one-cycle pulse at the end of a frame's stop bit
//   ps2_clk   generated PS/2 clock, idle high
//   ps2_data  generated PS/2 data, idle high
module ps2_kbd_tx #(
    parameter int unsigned CLK_HALF = 50,
    parameter int unsigned GAP      = 200,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    // A zero-length gap is treated as one cycle so the GAP state is always visited.
    localparam int unsigned GAP_N  = (GAP < 1) ? 1 : GAP;
    localparam int unsigned PH_MAX = (CLK_HALF > GAP_N) ? CLK_HALF : GAP_N;
    localparam int unsigned PH_W   = $clog2(PH_MAX);

    localparam logic [PH_W-1:0] PH_HALF_LAST = PH_W'(CLK_HALF - 1);
    localparam logic [PH_W-1:0] PH_GAP_LAST  = PH_W'(GAP_N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // FIFO storage and control
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_c;
    logic              pop_c;
    logic [7:0]        head;

    // FSM state
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_nxt;
    logic [10:0]       shreg;
    logic [10:0]       shreg_nxt;
    logic [3:0]        bitcnt;
    logic [3:0]        bitcnt_nxt;

    // Next values of the registered outputs
    logic              clk_nxt;
    logic              data_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // A write while full is dropped, regardless of a same-cycle pop.
    assign push_c    = wr_en & ~full;
    assign head      = mem[rd_ptr];
    assign count_nxt = count + CNT_W'(push_c) - CNT_W'(pop_c);

    // FIFO pointers, occupancy and flags
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // FIFO data array (no reset needed; contents are qualified by count)
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= wr_data;
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= S_IDLE;
            phase    <= '0;
            shreg    <= '1;
            bitcnt   <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            shreg    <= shreg_nxt;
            bitcnt   <= bitcnt_nxt;
            ps2_clk  <= clk_nxt;
            ps2_data <= data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase + PH_W'(1);
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        pop_c      = 1'b0;

        case (state)
            S_IDLE: begin
                phase_nxt = '0;
                if (!empty) begin
                    pop_c      = 1'b1;
                    shreg_nxt  = {1'b1, ~^head, head, 1'b0};
                    bitcnt_nxt = '0;
                    state_nxt  = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase == PH_HALF_LAST) begin
                    phase_nxt = '0;
                    state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (phase == PH_HALF_LAST) begin
                    phase_nxt = '0;
                    if (bitcnt == 4'd10) begin
                        state_nxt = S_GAP;
                    end else begin
                        // Shifting here means ps2_data only moves on HIGH entry.
                        shreg_nxt  = {1'b1, shreg[10:1]};
                        bitcnt_nxt = bitcnt + 4'd1;
                        state_nxt  = S_HIGH;
                    end
                end
            end
            S_GAP: begin
                if (phase == PH_GAP_LAST) begin
                    phase_nxt = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                phase_nxt = '0;
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs follow the current state one register stage later, so the
        // end of the stop bit (done) lines up with the final ps2_clk rise.
        clk_nxt  = (state != S_LOW);
        data_nxt = ((state == S_HIGH) || (state == S_LOW)) ? shreg[0] : 1'b1;
        busy_nxt = (state != S_IDLE);
        done_nxt = (state == S_GAP) && (phase == '0);
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: self-checking bench for ps2_kbd_tx with a bench-side PS/2
// receiver that decodes frames on ps2_clk falls, plus an edge recorder that
// timestamps line transitions in clk cycles.
module tb_ps2_kbd_tx;

    localparam int CH = 4;
    localparam int GP = 8;
    localparam int AW = 3;
    localparam int FRAME = 22 * CH;
    localparam int SLOT  = FRAME + GP + 2;

    logic       clk = 1'b0;
    logic       clrn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, busy, done, ps2_clk, ps2_data;

    ps2_kbd_tx #(.CLK_HALF(CH), .GAP(GP), .ADDR_W(AW)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_wr;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge timestamps (cycle index of the edge after which the change is seen)
    int fall_q[$];
    int rise_q[$];
    int dfall_q[$];
    int done_q[$];
    int idle_q[$];
    logic prev_clk  = 1'b1;
    logic prev_data = 1'b1;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (clrn === 1'b1) begin
            if (prev_clk && !ps2_clk)   fall_q.push_back(cyc);
            if (!prev_clk && ps2_clk)   rise_q.push_back(cyc);
            if (prev_data && !ps2_data) dfall_q.push_back(cyc);
            if (done)                   done_q.push_back(cyc);
            if (prev_busy && !busy)     idle_q.push_back(cyc);
        end
        prev_clk  = ps2_clk;
        prev_data = ps2_data;
        prev_busy = busy;
    end

    // Bench PS/2 receiver: samples ps2_data on every ps2_clk fall
    logic [10:0] rx_bits;
    int          rx_n = 0;
    logic [7:0]  rx_byte_q[$];
    logic        rx_par_q[$];
    logic        rx_frm_q[$];

    always @(negedge ps2_clk or negedge clrn) begin
        if (!clrn) begin
            rx_n = 0;
        end else begin
            rx_bits[rx_n] = ps2_data;
            rx_n = rx_n + 1;
            if (rx_n == 11) begin
                rx_n = 0;
                rx_byte_q.push_back(rx_bits[8:1]);
                rx_par_q.push_back(rx_bits[9]);
                rx_frm_q.push_back((rx_bits[0] == 1'b0) && (rx_bits[10] == 1'b1));
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        fall_q.delete(); rise_q.delete(); dfall_q.delete();
        done_q.delete(); idle_q.delete();
        rx_byte_q.delete(); rx_par_q.delete(); rx_frm_q.delete();
    endtask

    // One-cycle write; t_wr is the index of the sampling edge.
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        t_wr  = cyc;
        wr_en = 1'b0;
    endtask

    // Pop one decoded frame and compare against the expected byte.
    task automatic expect_rx(input string nm, input logic [7:0] d);
        logic [7:0] b;
        logic       p;
        logic       f;
        b = 'x; p = 'x; f = 'x;
        if (rx_byte_q.size() > 0) begin
            b = rx_byte_q.pop_front();
            p = rx_par_q.pop_front();
            f = rx_frm_q.pop_front();
        end
        chk({nm, "_byte"}, 32'(b), 32'(d));
        chk({nm, "_par"},  32'(p), 32'(odd_par(d)));
        chk({nm, "_frm"},  32'(f), 32'd1);
    endtask

    // Odd parity bit: 1 when the byte has an even number of ones.
    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 0;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int t0;
        int n;
        logic [7:0] b;
        logic [7:0] exp_q[$];

        tbl[0] = '{8'h1C, 1'b0};
        tbl[1] = '{8'h00, 1'b1};
        tbl[2] = '{8'hF0, 1'b1};
        tbl[3] = '{8'hFF, 1'b1};
        tbl[4] = '{8'h01, 1'b0};
        tbl[5] = '{8'h80, 1'b0};
        tbl[6] = '{8'h55, 1'b1};
        tbl[7] = '{8'hA7, 1'b0};

        clrn = 1'b0; wr_en = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ps2_clk", 32'(ps2_clk), 1);
        chk("rst_ps2_data", 32'(ps2_data), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);

        // Idle after reset: no activity at all
        clrn = 1'b1;
        clear_q();
        repeat (100) @(negedge clk);
        chk("idle_falls", 32'(fall_q.size()), 0);
        chk("idle_dfalls", 32'(dfall_q.size()), 0);
        chk("idle_done", 32'(done_q.size()), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_empty", 32'(empty), 1);
        chk("idle_lines", 32'({ps2_clk, ps2_data}), 32'h3);

        // Single-frame table with timing
        for (int i = 0; i < 8; i++) begin
            clear_q();
            push(tbl[i].data);
            t0 = t_wr;
            @(negedge clk);
            chk("tbl_empty_after_wr", 32'(empty), 0);
            repeat (SLOT + 8) @(negedge clk);
            chk("tbl_start_lat", (dfall_q.size() > 0) ? 32'(dfall_q[0] - t0) : 32'hFFFF, 2);
            chk("tbl_nfalls", 32'(fall_q.size()), 11);
            chk("tbl_first_fall", (fall_q.size() > 0) ? 32'(fall_q[0] - t0) : 32'hFFFF, 32'(2 + CH));
            chk("tbl_ndone", 32'(done_q.size()), 1);
            chk("tbl_done_t", (done_q.size() > 0) ? 32'(done_q[0] - t0) : 32'hFFFF, 32'(2 + FRAME));
            chk("tbl_last_rise", (rise_q.size() == 11) ? 32'(rise_q[10] - t0) : 32'hFFFF, 32'(2 + FRAME));
            chk("tbl_idle_t", (idle_q.size() > 0) ? 32'(idle_q[0] - t0) : 32'hFFFF, 32'(2 + FRAME + GP));
            chk("tbl_par_const", 32'(odd_par(tbl[i].data)), 32'(tbl[i].par));
            expect_rx("tbl", tbl[i].data);
        end

        // Back-to-back frames 00 F0
        clear_q();
        push(8'h00);
        t0 = t_wr;
        push(8'hF0);
        repeat (2 * SLOT + 30) @(negedge clk);
        chk("b2b_nfalls", 32'(fall_q.size()), 22);
        chk("b2b_ndone", 32'(done_q.size()), 2);
        chk("b2b_gap", (dfall_q.size() > 1 && rise_q.size() > 10) ? 32'(dfall_q[1] - rise_q[10]) : 32'hFFFF,
            32'(GP + 1));
        chk("b2b_start2", (dfall_q.size() > 1) ? 32'(dfall_q[1] - t0) : 32'hFFFF, 32'(2 + FRAME + GP + 1));
        expect_rx("b2b0", 8'h00);
        expect_rx("b2b1", 8'hF0);

        // Overflow: burst of 9 while the first frame holds the FSM
        clear_q();
        exp_q.delete();
        push(8'h1C);
        exp_q.push_back(8'h1C);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            push(b);
            if (i < (1 << AW)) exp_q.push_back(b);
            if (i == 7) begin
                chk("ovf_full_at8", 32'(full), 1);
                chk("ovf_clear_at8", 32'(overflow), 0);
            end
            if (i == 8) begin
                chk("ovf_set_at9", 32'(overflow), 1);
                chk("ovf_full_at9", 32'(full), 1);
            end
        end
        repeat (10 * SLOT) @(negedge clk);
        chk("ovf_nframes", 32'(rx_byte_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) expect_rx("ovf", exp_q.pop_front());
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_empty_end", 32'(empty), 1);
        chk("ovf_full_end", 32'(full), 0);

        // Reset during data bit 3, with one more byte queued
        clear_q();
        push(8'h5A);
        push(8'h33);
        for (int w = 0; w < 400 && fall_q.size() < 5; w++) @(negedge clk);
        chk("rst_reach_bit3", 32'(fall_q.size() >= 5), 1);
        chk("rst_busy_before", 32'(busy), 1);
        clrn = 1'b0;
        #1;
        chk("rstf_ps2_clk", 32'(ps2_clk), 1);
        chk("rstf_ps2_data", 32'(ps2_data), 1);
        chk("rstf_busy", 32'(busy), 0);
        chk("rstf_done", 32'(done), 0);
        chk("rstf_empty", 32'(empty), 1);
        chk("rstf_overflow", 32'(overflow), 0);
        @(negedge clk);
        clrn = 1'b1;
        clear_q();
        repeat (3 * SLOT) @(negedge clk);
        chk("rstf_no_falls", 32'(fall_q.size()), 0);
        chk("rstf_no_frames", 32'(rx_byte_q.size()), 0);
        chk("rstf_idle", 32'(busy), 0);
        push(8'h1C);
        repeat (SLOT + 8) @(negedge clk);
        expect_rx("rstf_after", 8'h1C);

        // Randomized bursts (never more than the FIFO can hold)
        for (int r = 0; r < 6; r++) begin
            clear_q();
            exp_q.delete();
            n = int'($urandom_range(1, 1 << AW));
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                push(b);
                exp_q.push_back(b);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            repeat (n * SLOT + 40) @(negedge clk);
            chk("rnd_nframes", 32'(rx_byte_q.size()), 32'(n));
            chk("rnd_ndone", 32'(done_q.size()), 32'(n));
            while (exp_q.size() > 0) expect_rx("rnd", exp_q.pop_front());
            chk("rnd_no_ovf", 32'(overflow), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
